// File: rtl/led_seq_core.sv
// LED sequencer core: fetches from a sync-read program RAM, executes show/delay/loop/rotate ops
// and drives a registered LED pattern, with a tick prescaler, start/pause control and halt status.
module led_seq_core #(
  parameter int PW   = 8,
  parameter int AW   = 8,
  parameter int IW   = 16,
  parameter int TICK = 195312
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  output logic [AW-1:0] addrRd,
  input  logic [IW-1:0] dataRd,
  output logic [PW-1:0] outPattern,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [2:0]    state
);

  localparam int PSW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [PSW-1:0] PRE_LAST = PSW'(TICK - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t         st, st_next;
  logic [3:0]     op;
  logic [7:0]     dly, lcnt, tcnt;
  logic [PSW-1:0] pre;
  logic           tick_done;
  logic           busy_next, halted_next;
  logic           unused_bits;

  assign op          = dataRd[IW-1:IW-4];
  assign addrRd      = pc;
  assign state       = st;
  assign unused_bits = ^dataRd;
  // WAIT ends on the prescaler wrap that completes the dly-th tick.
  assign tick_done   = (pre == PRE_LAST) && (tcnt + 8'd1 == dly);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= S_IDLE;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      st     <= st_next;
      busy   <= busy_next;
      halted <= halted_next;
    end
  end

  always_comb begin
    st_next = st;
    case (st)
      S_IDLE:  st_next = S_IDLE;
      S_FETCH: st_next = S_DECODE;
      S_DECODE: begin
        case (op)
          4'h1, 4'h7, 4'h8, 4'h9: st_next = S_WAIT;
          4'hF:                   st_next = S_HALT;
          default:                st_next = S_FETCH;
        endcase
      end
      S_WAIT:  if (tick_done) st_next = S_FETCH;
      S_HALT:  st_next = S_HALT;
      default: st_next = S_IDLE;
    endcase
    if (start)      st_next = S_FETCH;
    else if (pause) st_next = st;
  end

  always_comb begin
    busy_next   = (st_next == S_FETCH) || (st_next == S_DECODE) || (st_next == S_WAIT);
    halted_next = (st_next == S_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= '0;
      outPattern <= '0;
      dly        <= 8'd1;
      lcnt       <= 8'd0;
      tcnt       <= 8'd0;
      pre        <= '0;
    end else if (start) begin
      pc         <= '0;
      outPattern <= '0;
      dly        <= 8'd1;
      lcnt       <= 8'd0;
      tcnt       <= 8'd0;
      pre        <= '0;
    end else if (!pause) begin
      case (st)
        S_DECODE: begin
          pc   <= pc + AW'(1);
          pre  <= '0;
          tcnt <= 8'd0;
          case (op)
            4'h1: outPattern <= dataRd[PW-1:0];
            4'h2: dly <= (dataRd[7:0] == 8'd0) ? 8'd1 : dataRd[7:0];
            4'h3: pc <= dataRd[AW-1:0];
            4'h5: lcnt <= dataRd[7:0];
            4'h6: begin
              if (lcnt > 8'd1) begin
                lcnt <= lcnt - 8'd1;
                pc   <= dataRd[AW-1:0];
              end else begin
                lcnt <= 8'd0;
              end
            end
            4'h7: outPattern <= (outPattern << 1) | (outPattern >> (PW - 1));
            4'h8: outPattern <= (outPattern >> 1) | (outPattern << (PW - 1));
            4'h9: outPattern <= outPattern ^ dataRd[PW-1:0];
            4'hF: pc <= pc;
            default: ;
          endcase
        end
        S_WAIT: begin
          if (pre == PRE_LAST) begin
            pre  <= '0;
            tcnt <= tcnt + 8'd1;
          end else begin
            pre <= pre + PSW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
